// File: rtl/cache_sa_lru_policy_pkg.sv
// rtl/cache_sa_lru_policy_pkg.sv - shared encodings for the set-associative replacement tracker
package cache_sa_lru_policy_pkg;

    localparam int POLICY_LRU = 0;
    localparam int POLICY_MRU = 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/cache_sa_victim_select.sv
// rtl/cache_sa_victim_select.sv - combinational victim choice for one set
module cache_sa_victim_select
    import cache_sa_lru_policy_pkg::*;
#(
    parameter int CACHE_WAYS = 4,
    parameter int BW_WAY     = $clog2(CACHE_WAYS),
    parameter int POLICY     = POLICY_LRU
) (
    input  logic [CACHE_WAYS-1:0][BW_WAY-1:0] i_age,
    input  logic [CACHE_WAYS-1:0]             i_valid,
    input  logic [CACHE_WAYS-1:0]             i_dirty,
    output logic [BW_WAY-1:0]                 o_way,
    output logic                              o_dirty
);

    localparam logic [BW_WAY-1:0] LP_TARGET = (POLICY == POLICY_MRU) ? '0 : BW_WAY'(CACHE_WAYS - 1);

    logic              w_inv_found;
    logic [BW_WAY-1:0] w_inv_way;
    logic [BW_WAY-1:0] w_age_way;

    // Descending scan so the lowest-index invalid way wins.
    always_comb begin
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        w_age_way   = '0;
        for (int w = CACHE_WAYS - 1; w >= 0; w--) begin
            if (!i_valid[w]) begin
                w_inv_found = 1'b1;
                w_inv_way   = BW_WAY'(w);
            end
            if (i_age[w] == LP_TARGET) begin
                w_age_way = BW_WAY'(w);
            end
        end
    end

    assign o_way   = w_inv_found ? w_inv_way : w_age_way;
    assign o_dirty = w_inv_found ? 1'b0 : i_dirty[w_age_way];

endmodule

// File: rtl/cache_sa_lru_policy.sv
// rtl/cache_sa_lru_policy.sv - per-set age stacks, valid/dirty bits, victim queries and flush sweep
module cache_sa_lru_policy
    import cache_sa_lru_policy_pkg::*;
#(
    parameter int CACHE_SETS = 16,
    parameter int CACHE_WAYS = 4,
    parameter int BW_SET     = $clog2(CACHE_SETS),
    parameter int BW_WAY     = $clog2(CACHE_WAYS),
    parameter int POLICY     = POLICY_LRU
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              enable_i,
    input  logic              hit_i,
    input  logic [BW_SET-1:0] hit_set_i,
    input  logic [BW_WAY-1:0] hit_way_i,
    input  logic              hit_rw_i,
    input  logic              fill_i,
    input  logic [BW_SET-1:0] fill_set_i,
    input  logic [BW_WAY-1:0] fill_way_i,
    input  logic              fill_rw_i,
    input  logic              victim_req_i,
    input  logic [BW_SET-1:0] victim_set_i,
    output logic              victim_valid_o,
    output logic [BW_WAY-1:0] victim_way_o,
    output logic              victim_dirty_o,
    input  logic              clean_i,
    input  logic [BW_SET-1:0] clean_set_i,
    input  logic [BW_WAY-1:0] clean_way_i,
    input  logic              flush_req_i,
    output logic              flush_busy_o,
    output logic              flush_done_o,
    output logic              collision_o,
    output logic              flag_writeback_o
);

    typedef logic [CACHE_WAYS-1:0][BW_WAY-1:0] ages_t;

    ages_t                 r_age   [CACHE_SETS];
    logic [CACHE_WAYS-1:0] r_valid [CACHE_SETS];
    logic [CACHE_WAYS-1:0] r_dirty [CACHE_SETS];
    logic [1:0]            r_state;
    logic [BW_SET-1:0]     r_ptr;
    logic                  r_victim_valid;
    logic [BW_WAY-1:0]     r_victim_way;
    logic                  r_victim_dirty;
    logic                  r_collision;
    logic                  r_flag_wb;

    ages_t                 w_age_nxt   [CACHE_SETS];
    logic [CACHE_WAYS-1:0] w_valid_nxt [CACHE_SETS];
    logic [CACHE_WAYS-1:0] w_dirty_nxt [CACHE_SETS];
    logic                  w_active;
    logic [BW_SET-1:0]     w_acc_set;
    logic [BW_WAY-1:0]     w_acc_way;
    logic [BW_WAY-1:0]     w_old_age;
    logic [BW_WAY-1:0]     w_sel_way;
    logic                  w_sel_dirty;

    assign w_active  = enable_i && (r_state == ST_IDLE);
    assign w_acc_set = fill_i ? fill_set_i : hit_set_i;
    assign w_acc_way = fill_i ? fill_way_i : hit_way_i;
    assign w_old_age = r_age[w_acc_set][w_acc_way];

    // Clean is applied before the access so a coinciding store or fill takes precedence.
    always_comb begin
        w_age_nxt   = r_age;
        w_valid_nxt = r_valid;
        w_dirty_nxt = r_dirty;
        if (w_active) begin
            if (clean_i) begin
                w_dirty_nxt[clean_set_i][clean_way_i] = 1'b0;
            end
            if (fill_i) begin
                w_valid_nxt[fill_set_i][fill_way_i] = 1'b1;
                w_dirty_nxt[fill_set_i][fill_way_i] = fill_rw_i;
            end else if (hit_i && hit_rw_i) begin
                w_dirty_nxt[hit_set_i][hit_way_i] = 1'b1;
            end
            if (fill_i || hit_i) begin
                for (int w = 0; w < CACHE_WAYS; w++) begin
                    if (BW_WAY'(w) == w_acc_way) begin
                        w_age_nxt[w_acc_set][w] = '0;
                    end else if (r_age[w_acc_set][w] < w_old_age) begin
                        w_age_nxt[w_acc_set][w] = r_age[w_acc_set][w] + 1'b1;
                    end
                end
            end
        end
        if (r_state == ST_FLUSH) begin
            w_valid_nxt[r_ptr] = '0;
            w_dirty_nxt[r_ptr] = '0;
            for (int w = 0; w < CACHE_WAYS; w++) begin
                w_age_nxt[r_ptr][w] = BW_WAY'(w);
            end
        end
    end

    // Selection looks at next-state values so a same-cycle update to the queried set is forwarded.
    cache_sa_victim_select #(
        .CACHE_WAYS (CACHE_WAYS),
        .BW_WAY     (BW_WAY),
        .POLICY     (POLICY)
    ) u_victim_select (
        .i_age   (w_age_nxt[victim_set_i]),
        .i_valid (w_valid_nxt[victim_set_i]),
        .i_dirty (w_dirty_nxt[victim_set_i]),
        .o_way   (w_sel_way),
        .o_dirty (w_sel_dirty)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int s = 0; s < CACHE_SETS; s++) begin
                for (int w = 0; w < CACHE_WAYS; w++) begin
                    r_age[s][w] <= BW_WAY'(w);
                end
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
            end
            r_state        <= ST_IDLE;
            r_ptr          <= '0;
            r_victim_valid <= 1'b0;
            r_victim_way   <= '0;
            r_victim_dirty <= 1'b0;
            r_collision    <= 1'b0;
            r_flag_wb      <= 1'b0;
        end else begin
            r_victim_valid <= 1'b0;
            r_collision    <= 1'b0;
            r_flag_wb      <= 1'b0;
            if (enable_i) begin
                r_age       <= w_age_nxt;
                r_valid     <= w_valid_nxt;
                r_dirty     <= w_dirty_nxt;
                r_collision <= w_active && hit_i && fill_i;
                if (w_active && victim_req_i) begin
                    r_victim_valid <= 1'b1;
                    r_victim_way   <= w_sel_way;
                    r_victim_dirty <= w_sel_dirty;
                    r_flag_wb      <= w_sel_dirty;
                end
                case (r_state)
                    ST_IDLE: begin
                        if (flush_req_i) begin
                            r_state <= ST_FLUSH;
                            r_ptr   <= '0;
                        end
                    end
                    ST_FLUSH: begin
                        r_ptr <= r_ptr + 1'b1;
                        if (r_ptr == BW_SET'(CACHE_SETS - 1)) begin
                            r_state <= ST_DONE;
                        end
                    end
                    ST_DONE:  r_state <= ST_IDLE;
                    default:  r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign victim_valid_o   = r_victim_valid && enable_i;
    assign victim_way_o     = r_victim_way;
    assign victim_dirty_o   = r_victim_dirty;
    assign flag_writeback_o = r_flag_wb && enable_i;
    assign collision_o      = r_collision && enable_i;
    assign flush_busy_o     = (r_state != ST_IDLE);
    assign flush_done_o     = (r_state == ST_DONE) && enable_i;

endmodule

// File: tb/tb_cache_sa_lru_policy.sv
// tb/tb_cache_sa_lru_policy.sv - directed table, flush/reset sequences and random traffic vs a recency-list model
module tb_cache_sa_lru_policy;

    localparam int SETS = 16;
    localparam int WAYS = 4;

    logic       clk, rst, en;
    logic       hit, hrw, fill, frw, clean, vreq, freq;
    logic [3:0] hs, fs, cs, vs;
    logic [1:0] hw, fw, cw;

    logic       vv_l, dl_l, busy_l, done_l, col_l, wb_l;
    logic [1:0] way_l;
    logic       vv_m, dl_m, busy_m, done_m, col_m, wb_m;
    logic [1:0] way_m;

    cache_sa_lru_policy #(.CACHE_SETS(SETS), .CACHE_WAYS(WAYS), .POLICY(0)) dut (
        .clock_i(clk), .reset_i(rst), .enable_i(en),
        .hit_i(hit), .hit_set_i(hs), .hit_way_i(hw), .hit_rw_i(hrw),
        .fill_i(fill), .fill_set_i(fs), .fill_way_i(fw), .fill_rw_i(frw),
        .victim_req_i(vreq), .victim_set_i(vs),
        .victim_valid_o(vv_l), .victim_way_o(way_l), .victim_dirty_o(dl_l),
        .clean_i(clean), .clean_set_i(cs), .clean_way_i(cw),
        .flush_req_i(freq), .flush_busy_o(busy_l), .flush_done_o(done_l),
        .collision_o(col_l), .flag_writeback_o(wb_l)
    );

    cache_sa_lru_policy #(.CACHE_SETS(SETS), .CACHE_WAYS(WAYS), .POLICY(1)) dut_mru (
        .clock_i(clk), .reset_i(rst), .enable_i(en),
        .hit_i(hit), .hit_set_i(hs), .hit_way_i(hw), .hit_rw_i(hrw),
        .fill_i(fill), .fill_set_i(fs), .fill_way_i(fw), .fill_rw_i(frw),
        .victim_req_i(vreq), .victim_set_i(vs),
        .victim_valid_o(vv_m), .victim_way_o(way_m), .victim_dirty_o(dl_m),
        .clean_i(clean), .clean_set_i(cs), .clean_way_i(cw),
        .flush_req_i(freq), .flush_busy_o(busy_m), .flush_done_o(done_m),
        .collision_o(col_m), .flag_writeback_o(wb_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int n_vec = 0;
    int n_err = 0;

    // Model: rec[s][k] is the way at recency position k (0 = most recent).
    int  rec [SETS][WAYS];
    bit  mv  [SETS][WAYS];
    bit  md  [SETS][WAYS];
    int  m_fc;
    bit  e_vv, e_col, e_wbl, e_wbm, e_dl, e_dm;
    int  e_wl, e_wm;

    typedef struct {
        bit hit; int hs; int hw; bit hrw;
        bit fill; int fs; int fw; bit frw;
        bit clean; int cs; int cw;
        bit vreq; int vs;
        bit chk; int e_wl; int e_wm; bit e_dl; bit e_dm; bit e_col;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_clear_sets();
        for (int s = 0; s < SETS; s++) begin
            for (int k = 0; k < WAYS; k++) begin
                rec[s][k] = k;
                mv[s][k]  = 1'b0;
                md[s][k]  = 1'b0;
            end
        end
    endfunction

    function automatic void model_reset();
        model_clear_sets();
        m_fc = 0;
        e_vv = 0; e_col = 0; e_wbl = 0; e_wbm = 0;
        e_wl = 0; e_wm = 0; e_dl = 0; e_dm = 0;
    endfunction

    function automatic void touch(input int s, input int a);
        int p = 0;
        for (int k = 0; k < WAYS; k++) if (rec[s][k] == a) p = k;
        for (int k = p; k > 0; k--) rec[s][k] = rec[s][k-1];
        rec[s][0] = a;
    endfunction

    function automatic void mvict(input int s, input int pol, output int way, output bit d);
        way = -1;
        for (int w = WAYS - 1; w >= 0; w--) if (!mv[s][w]) way = w;
        if (way >= 0) begin
            d = 1'b0;
        end else begin
            way = pol ? rec[s][0] : rec[s][WAYS-1];
            d   = md[s][way];
        end
    endfunction

    task automatic model_step();
        e_vv = 0; e_col = 0; e_wbl = 0; e_wbm = 0;
        if (!en) return;
        if (m_fc == 0) begin
            if (clean) md[cs][cw] = 1'b0;
            if (fill) begin
                touch(int'(fs), int'(fw));
                mv[fs][fw] = 1'b1;
                md[fs][fw] = frw;
            end else if (hit) begin
                touch(int'(hs), int'(hw));
                if (hrw) md[hs][hw] = 1'b1;
            end
            e_col = hit && fill;
            if (vreq) begin
                e_vv = 1;
                mvict(int'(vs), 0, e_wl, e_dl);
                mvict(int'(vs), 1, e_wm, e_dm);
                e_wbl = e_dl;
                e_wbm = e_dm;
            end
            if (freq) m_fc = 1;
        end else if (m_fc == SETS + 1) begin
            m_fc = 0;
        end else begin
            m_fc++;
            if (m_fc == SETS + 1) model_clear_sets();
        end
    endtask

    task automatic cmp_model();
        chk("vv_lru", vv_l, e_vv);
        chk("vv_mru", vv_m, e_vv);
        chk("way_lru", way_l, e_wl);
        chk("way_mru", way_m, e_wm);
        chk("dirty_lru", dl_l, e_dl);
        chk("dirty_mru", dl_m, e_dm);
        chk("wb_lru", wb_l, e_wbl);
        chk("wb_mru", wb_m, e_wbm);
        chk("collision", col_l, e_col);
        chk("collision_mru", col_m, e_col);
        chk("busy", busy_l, m_fc != 0);
        chk("busy_mru", busy_m, m_fc != 0);
        chk("done", done_l, (m_fc == SETS + 1) && en);
        chk("done_mru", done_m, (m_fc == SETS + 1) && en);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        model_step();
        cmp_model();
    endtask

    task automatic idle();
        hit = 0; hs = 0; hw = 0; hrw = 0;
        fill = 0; fs = 0; fw = 0; frw = 0;
        clean = 0; cs = 0; cw = 0;
        vreq = 0; vs = 0; freq = 0;
    endtask

    function automatic vec_t vz();
        vec_t v;
        v = '{default: 0};
        return v;
    endfunction

    function automatic vec_t vf(input int s, input int w, input bit rw);
        vec_t v = vz();
        v.fill = 1; v.fs = s; v.fw = w; v.frw = rw;
        return v;
    endfunction

    function automatic vec_t vh(input int s, input int w, input bit rw);
        vec_t v = vz();
        v.hit = 1; v.hs = s; v.hw = w; v.hrw = rw;
        return v;
    endfunction

    function automatic vec_t vc(input int s, input int w);
        vec_t v = vz();
        v.clean = 1; v.cs = s; v.cw = w;
        return v;
    endfunction

    function automatic vec_t vq(input vec_t vin, input int s, input int wl, input int wm,
                                input bit dl, input bit dm, input bit col);
        vec_t v = vin;
        v.vreq = 1; v.vs = s; v.chk = 1;
        v.e_wl = wl; v.e_wm = wm; v.e_dl = dl; v.e_dm = dm; v.e_col = col;
        return v;
    endfunction

    task automatic apply_vec(input vec_t v);
        hit = v.hit; hs = 4'(v.hs); hw = 2'(v.hw); hrw = v.hrw;
        fill = v.fill; fs = 4'(v.fs); fw = 2'(v.fw); frw = v.frw;
        clean = v.clean; cs = 4'(v.cs); cw = 2'(v.cw);
        vreq = v.vreq; vs = 4'(v.vs);
        cyc();
        if (v.chk) begin
            chk("tbl_vv", vv_l, 1);
            chk("tbl_way_lru", way_l, v.e_wl);
            chk("tbl_way_mru", way_m, v.e_wm);
            chk("tbl_dirty_lru", dl_l, v.e_dl);
            chk("tbl_dirty_mru", dl_m, v.e_dm);
            chk("tbl_wb_lru", wb_l, v.e_dl);
            chk("tbl_wb_mru", wb_m, v.e_dm);
            chk("tbl_collision", col_l, v.e_col);
        end
        idle();
    endtask

    initial begin
        vec_t v;
        int   busy_n, done_at;
        bit   saw_done;

        idle();
        en  = 1;
        rst = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vv", vv_l, 0);
        chk("rst_way", way_l, 0);
        chk("rst_dirty", dl_l, 0);
        chk("rst_busy", busy_l, 0);
        chk("rst_done", done_l, 0);
        chk("rst_col", col_l, 0);
        rst = 0;

        tbl.push_back(vq(vz(), 3, 0, 0, 0, 0, 0));
        for (int w = 0; w < WAYS; w++) tbl.push_back(vf(3, w, 0));
        tbl.push_back(vq(vz(), 3, 0, 3, 0, 0, 0));
        for (int w = 0; w < WAYS; w++) tbl.push_back(vf(5, w, 0));
        tbl.push_back(vh(5, 2, 0));
        tbl.push_back(vh(5, 0, 0));
        tbl.push_back(vh(5, 3, 0));
        tbl.push_back(vh(5, 1, 0));
        tbl.push_back(vq(vz(), 5, 2, 1, 0, 0, 0));
        tbl.push_back(vf(7, 1, 0));
        tbl.push_back(vh(7, 1, 1));
        tbl.push_back(vf(7, 0, 0));
        tbl.push_back(vf(7, 2, 0));
        tbl.push_back(vf(7, 3, 0));
        tbl.push_back(vq(vz(), 7, 1, 3, 1, 0, 0));
        tbl.push_back(vc(7, 1));
        tbl.push_back(vq(vz(), 7, 1, 3, 0, 0, 0));
        tbl.push_back(vq(vz(), 5, 2, 1, 0, 0, 0));
        v = vh(7, 1, 1); v.clean = 1; v.cs = 7; v.cw = 1;
        tbl.push_back(vq(v, 7, 0, 1, 0, 1, 0));
        for (int w = 0; w < WAYS; w++) tbl.push_back(vf(2, w, 0));
        tbl.push_back(vq(vh(2, 0, 0), 2, 1, 0, 0, 0, 0));
        v = vf(2, 3, 0); v.hit = 1; v.hs = 2; v.hw = 1; v.hrw = 1;
        tbl.push_back(vq(v, 2, 1, 3, 0, 0, 1));
        foreach (tbl[i]) apply_vec(tbl[i]);

        for (int s = 8; s < 12; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                fill = 1; fs = 4'(s); fw = 2'(w); frw = 1;
                cyc();
            end
        end
        idle();
        freq = 1;
        cyc();
        freq = 0;
        busy_n  = 0;
        done_at = 0;
        for (int k = 1; k <= 40 && busy_l; k++) begin
            busy_n++;
            if (done_l) done_at = busy_n;
            if (k == 5) begin vreq = 1; vs = 4'd3; end
            cyc();
            if (k == 5) chk("midsweep_vv", vv_l, 0);
            vreq = 0;
        end
        chk("flush_busy_cycles", busy_n, SETS + 1);
        chk("flush_done_cycle", done_at, SETS + 1);
        for (int s = 0; s < SETS; s++) begin
            vreq = 1; vs = 4'(s);
            cyc();
            chk("post_flush_way_lru", way_l, 0);
            chk("post_flush_way_mru", way_m, 0);
            chk("post_flush_dirty", dl_l, 0);
        end
        idle();

        for (int w = 0; w < WAYS; w++) begin
            fill = 1; fs = 4'd1; fw = 2'(w); frw = 1;
            cyc();
        end
        idle();
        vreq = 1; vs = 4'd1;
        cyc();
        chk("pre_rst_way_mru", way_m, 3);
        chk("pre_rst_dirty", dl_l, 1);
        idle();
        freq = 1;
        cyc();
        freq = 0;
        repeat (6) cyc();
        chk("midsweep_busy", busy_l, 1);
        #2;
        rst = 1;
        #1;
        chk("async_rst_busy", busy_l, 0);
        chk("async_rst_done", done_l, 0);
        chk("async_rst_way_mru", way_m, 0);
        chk("async_rst_dirty", dl_l, 0);
        chk("async_rst_vv", vv_l, 0);
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        saw_done = 0;
        for (int k = 0; k < 25; k++) begin
            cyc();
            if (done_l) saw_done = 1;
        end
        chk("no_done_after_abort", saw_done, 0);

        for (int n = 0; n < 2500; n++) begin
            en    = ($urandom_range(0, 9) != 0);
            hit   = $urandom_range(0, 1);
            hs    = 4'($urandom_range(0, 3)); hw = 2'($urandom_range(0, 3)); hrw = $urandom_range(0, 1);
            fill  = ($urandom_range(0, 9) < 3);
            fs    = 4'($urandom_range(0, 3)); fw = 2'($urandom_range(0, 3)); frw = $urandom_range(0, 1);
            clean = ($urandom_range(0, 4) == 0);
            cs    = 4'($urandom_range(0, 3)); cw = 2'($urandom_range(0, 3));
            vreq  = $urandom_range(0, 1);
            vs    = 4'($urandom_range(0, 3));
            freq  = ($urandom_range(0, 149) == 0);
            cyc();
        end
        idle();
        en = 1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
